mpu_fault_unit: RTL and testbench
=================================

Name: mpu_fault_unit

Overview:
- Consumer end of the MPU fault path: samples the per-access fault flag plus the offending access context, and latches one fault record.
- Raises a level interrupt request toward the n-CLIC and holds it until the handler acknowledges it, either by CLIC ack or by a CSR write.
- Counts faults that arrive while a record is pending, so software can detect lost records.
- Record is software-visible through a small read-mostly CSR window placed directly above the MPU configuration CSRs.

Parameters:
- CsrBase, 'h420, CSR address of the first fault register; occupies CsrBase..CsrBase+2.
- CntWidth, 8, width of the saturating overflow (missed-fault) counter; legal range 1..16.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- mem_valid  input  1  a load/store access is presented this cycle (one pulse per access)
- mem_fault_in  input  1  MPU fault flag for the presented access (combinational from MPU)
- addr  input  16  address of the presented access
- op  input  7  opcode of the presented access (0000011 load, 0100011 store)
- id  input  3  task/map id active for the access
- interrupt_prio  input  8  current running priority
- irq_ack  input  1  n-CLIC has taken the fault interrupt (1-cycle pulse)
- csr_addr  input  12  CSR address
- csr_read_en  input  1  CSR read strobe
- csr_write_en  input  1  CSR write strobe
- csr_wdata  input  32  CSR write data
- csr_rdata  output  32  CSR read data, combinational, 0 when address does not hit
- fault_irq_out  output  1  fault interrupt request to n-CLIC (level)
- fault_pending  output  1  a valid record is held

Behaviour:
- Fault event: mem_valid && mem_fault_in sampled at a rising clk edge.
  - mem_fault_in without mem_valid is ignored.
- FSM has two states, IDLE and PENDING.
  - IDLE + event -> PENDING.
    - Record {addr, op[5] (0 = load, 1 = store), id, interrupt_prio} is captured at that same edge.
    - fault_irq_out and fault_pending are 1 from the next cycle (1-cycle latency).
  - PENDING + event -> stay PENDING.
    - Record is not overwritten; overflow count increments, saturating at 2^CntWidth-1.
  - PENDING + release -> IDLE. Release is irq_ack, or a CSR write to STATUS with csr_wdata[0] = 1.
    - fault_irq_out and fault_pending drop the next cycle.
    - Overflow count clears to 0.
  - Release and event in the same cycle: release wins first, then the new event is captured.
    - Next state is PENDING with the new record; overflow count is 0.
  - irq_ack or a STATUS clear in IDLE: no effect.
- fault_irq_out is identical to fault_pending. Both are registered outputs with no combinational path from inputs.
- CSR map (read data zero-extended to 32 bits):
  - CsrBase+0 FAULT_ADDR: [15:0] addr. Read-only.
  - CsrBase+1 FAULT_INFO: [7:0] prio, [10:8] id, [11] store flag. Read-only.
  - CsrBase+2 STATUS: [0] pending, [16+CntWidth-1:16] overflow count.
    - Write 1 to bit0 releases; all other bits are ignored.
- Writes to FAULT_ADDR and FAULT_INFO are ignored. Record fields keep their last value after release.
- Reset (asynchronous, reset=0) forces state IDLE and clears the record, counter and outputs to 0.
  - Reset during PENDING drops the interrupt immediately.
  - csr_rdata reads 0 for all registers while held in reset.
- Concurrent CSR read and event in the same cycle: the read returns the pre-edge value.

Test Plan:
1. Reset, then mem_valid=1, mem_fault_in=1, addr=16'h1234, op=0100011, id=5, prio=8'h03 for 1 cycle -> next cycle fault_irq_out=1; FAULT_ADDR reads 0x1234; FAULT_INFO reads 0x0D03; STATUS reads 0x1.
2. From case 1, three more fault events with addr=16'h2000 -> FAULT_ADDR still 0x1234; STATUS reads 0x00030001. Then irq_ack pulse -> next cycle fault_irq_out=0 and STATUS reads 0.
3. CntWidth=2, pending record plus 5 extra events -> count saturates at 3; STATUS reads 0x00030001.
4. Pending, with irq_ack and a new event (addr=16'h0040, load, id=2) in the same cycle -> remains pending; FAULT_ADDR=0x0040; FAULT_INFO[11]=0; count=0.
5. mem_fault_in=1 with mem_valid=0 for 10 cycles -> no capture, fault_irq_out stays 0. Then a CSR write STATUS=1 in IDLE -> no change.
6. Pending, assert reset=0 mid-cycle -> fault_irq_out and fault_pending go 0 without waiting for clk. After release, all CSRs read 0; a CSR read of address CsrBase+3 returns 0.

Source files
------------

// File: rtl/mpu_fault_unit_if.sv
// Bus bundle for mpu_fault_unit: the MPU access/fault sideband, the n-CLIC
// handshake and the CSR window. The master drives it, the fault unit is the slave.
interface mpu_fault_unit_if;
    logic        mem_valid;
    logic        mem_fault_in;
    logic [15:0] addr;
    logic [6:0]  op;
    logic [2:0]  id;
    logic [7:0]  interrupt_prio;
    logic        irq_ack;
    logic [11:0] csr_addr;
    logic        csr_read_en;
    logic        csr_write_en;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        fault_irq_out;
    logic        fault_pending;

    modport master (
        output mem_valid, mem_fault_in, addr, op, id, interrupt_prio, irq_ack,
        output csr_addr, csr_read_en, csr_write_en, csr_wdata,
        input  csr_rdata, fault_irq_out, fault_pending
    );

    modport slave (
        input  mem_valid, mem_fault_in, addr, op, id, interrupt_prio, irq_ack,
        input  csr_addr, csr_read_en, csr_write_en, csr_wdata,
        output csr_rdata, fault_irq_out, fault_pending
    );
endinterface

// File: rtl/mpu_fault_unit.sv
// MPU fault consumer: latches the first faulting access, raises a level IRQ until
// released, and counts faults lost while a record is pending.
module mpu_fault_unit #(
    parameter logic [11:0] CsrBase  = 12'h420,
    parameter int          CntWidth = 8
) (
    input logic            clk,
    input logic            reset,
    mpu_fault_unit_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    state_e              state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic                store_q, store_d;
    logic [2:0]          id_q, id_d;
    logic [7:0]          prio_q, prio_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic                event_s;
    logic                status_hit_s;
    logic                release_s;
    logic                capture_s;
    logic                pending_s;
    logic [31:0]         rdata_s;

    assign event_s      = bus.mem_valid & bus.mem_fault_in;
    assign status_hit_s = (bus.csr_addr == (CsrBase + 12'd2));
    assign release_s    = bus.irq_ack | (bus.csr_write_en & status_hit_s & bus.csr_wdata[0]);
    // A release in the same cycle frees the slot, so the new event is taken as a fresh record.
    assign capture_s    = event_s & ((state_q == IDLE) | release_s);

    // State and record registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= 16'h0000;
            store_q <= 1'b0;
            id_q    <= 3'd0;
            prio_q  <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            id_q    <= id_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (event_s) begin
                    state_d = PENDING;
                end else begin
                    state_d = IDLE;
                end
            end
            PENDING: begin
                if (release_s && !event_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = PENDING;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Record capture and saturating missed-fault counter
    always_comb begin
        addr_d  = addr_q;
        store_d = store_q;
        id_d    = id_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        if (capture_s) begin
            addr_d  = bus.addr;
            store_d = bus.op[5];
            id_d    = bus.id;
            prio_d  = bus.interrupt_prio;
        end else begin
            addr_d  = addr_q;
        end
        if (state_q == PENDING) begin
            if (release_s) begin
                cnt_d = '0;
            end else if (event_s && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + {{(CntWidth-1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Outputs come straight from the state register
    always_comb begin
        pending_s = (state_q == PENDING);
    end

    // CSR read mux; unmapped addresses read zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (bus.csr_addr)
            CsrBase: begin
                rdata_s[15:0] = addr_q;
            end
            CsrBase + 12'd1: begin
                rdata_s[7:0]  = prio_q;
                rdata_s[10:8] = id_q;
                rdata_s[11]   = store_q;
            end
            CsrBase + 12'd2: begin
                rdata_s[0]             = pending_s;
                rdata_s[16 +: CntWidth] = cnt_q;
            end
            default: rdata_s = 32'h0000_0000;
        endcase
    end

    assign bus.fault_pending = pending_s;
    assign bus.fault_irq_out = pending_s;
    assign bus.csr_rdata     = rdata_s;

endmodule

// File: tb/tb_mpu_fault_unit.sv
// Scoreboard bench for mpu_fault_unit: two instances (CntWidth 8 and 2) share stimulus;
// every CSR read pushes its expectation and a monitor pops and compares.
module tb_mpu_fault_unit;

    localparam logic [11:0] BASE   = 12'h420;
    localparam logic [11:0] A_ADDR = 12'h420;
    localparam logic [11:0] A_INFO = 12'h421;
    localparam logic [11:0] A_STAT = 12'h422;
    localparam logic [6:0]  OP_LD  = 7'b0000011;
    localparam logic [6:0]  OP_ST  = 7'b0100011;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
        bit          sel;
    } exp_t;

    logic clk;
    logic reset;
    logic chk_strobe;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    mpu_fault_unit_if ifa ();
    mpu_fault_unit_if ifb ();

    assign ifb.mem_valid      = ifa.mem_valid;
    assign ifb.mem_fault_in   = ifa.mem_fault_in;
    assign ifb.addr           = ifa.addr;
    assign ifb.op             = ifa.op;
    assign ifb.id             = ifa.id;
    assign ifb.interrupt_prio = ifa.interrupt_prio;
    assign ifb.irq_ack        = ifa.irq_ack;
    assign ifb.csr_addr       = ifa.csr_addr;
    assign ifb.csr_read_en    = ifa.csr_read_en;
    assign ifb.csr_write_en   = ifa.csr_write_en;
    assign ifb.csr_wdata      = ifa.csr_wdata;

    mpu_fault_unit #(.CsrBase(BASE), .CntWidth(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    mpu_fault_unit #(.CsrBase(BASE), .CntWidth(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare on every CSR read (sampled at negedge) or on an explicit async strobe
    initial begin
        exp_t        e;
        logic [31:0] a_rd;
        logic        a_irq;
        logic        a_pend;
        n_cmp = 0;
        n_bad = 0;
        forever begin
            @(negedge clk or posedge chk_strobe);
            if (ifa.csr_read_en || chk_strobe) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_underflow: got an output with no expectation queued at t=%0t", $time);
                end else begin
                    e      = sb.pop_front();
                    a_rd   = e.sel ? ifb.csr_rdata     : ifa.csr_rdata;
                    a_irq  = e.sel ? ifb.fault_irq_out : ifa.fault_irq_out;
                    a_pend = e.sel ? ifb.fault_pending : ifa.fault_pending;
                    if ((a_rd !== e.rd) || (a_irq !== e.irq) || (a_pend !== e.irq)) begin
                        n_bad++;
                        $display("FAIL %s: got rdata=%08h irq=%b pend=%b, want rdata=%08h irq=%b pend=%b",
                                 e.name, a_rd, a_irq, a_pend, e.rd, e.irq, e.irq);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_push(input string name, input logic [31:0] rd, input logic irq, input bit sel);
        exp_t e;
        e.name = name;
        e.rd   = rd;
        e.irq  = irq;
        e.sel  = sel;
        sb.push_back(e);
    endtask

    task automatic csr_read(input string name, input logic [11:0] a, input logic [31:0] rd,
                            input logic irq, input bit sel);
        expect_push(name, rd, irq, sel);
        ifa.csr_addr    = a;
        ifa.csr_read_en = 1'b1;
        tick();
        ifa.csr_read_en = 1'b0;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        ifa.csr_addr     = a;
        ifa.csr_wdata    = d;
        ifa.csr_write_en = 1'b1;
        tick();
        ifa.csr_write_en = 1'b0;
        ifa.csr_wdata    = 32'h0000_0000;
    endtask

    task automatic set_access(input logic [15:0] a, input logic [6:0] o, input logic [2:0] i,
                              input logic [7:0] p);
        ifa.mem_valid      = 1'b1;
        ifa.mem_fault_in   = 1'b1;
        ifa.addr           = a;
        ifa.op             = o;
        ifa.id             = i;
        ifa.interrupt_prio = p;
    endtask

    task automatic clr_access();
        ifa.mem_valid    = 1'b0;
        ifa.mem_fault_in = 1'b0;
    endtask

    task automatic fault(input logic [15:0] a, input logic [6:0] o, input logic [2:0] i,
                         input logic [7:0] p);
        set_access(a, o, i, p);
        tick();
        clr_access();
    endtask

    initial begin
        reset              = 1'b0;
        chk_strobe         = 1'b0;
        ifa.mem_valid      = 1'b0;
        ifa.mem_fault_in   = 1'b0;
        ifa.addr           = 16'h0000;
        ifa.op             = 7'b0000000;
        ifa.id             = 3'd0;
        ifa.interrupt_prio = 8'h00;
        ifa.irq_ack        = 1'b0;
        ifa.csr_addr       = 12'h000;
        ifa.csr_read_en    = 1'b0;
        ifa.csr_write_en   = 1'b0;
        ifa.csr_wdata      = 32'h0000_0000;
        tick();
        csr_read("rst_status", A_STAT, 32'h0000_0000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();

        // 1: first fault captured, IRQ one cycle later
        fault(16'h1234, OP_ST, 3'd5, 8'h03);
        csr_read("t1_addr", A_ADDR, 32'h0000_1234, 1'b1, 1'b0);
        csr_read("t1_info", A_INFO, 32'h0000_0D03, 1'b1, 1'b0);
        csr_read("t1_status", A_STAT, 32'h0000_0001, 1'b1, 1'b0);

        // 2: overflow counting, record kept, ack releases
        for (int k = 0; k < 3; k++) fault(16'h2000, OP_LD, 3'd1, 8'h07);
        csr_read("t2_addr_kept", A_ADDR, 32'h0000_1234, 1'b1, 1'b0);
        csr_read("t2_status_cnt3", A_STAT, 32'h0003_0001, 1'b1, 1'b0);
        csr_read("t2_b_status", A_STAT, 32'h0003_0001, 1'b1, 1'b1);
        ifa.irq_ack = 1'b1;
        tick();
        ifa.irq_ack = 1'b0;
        csr_read("t2_after_ack", A_STAT, 32'h0000_0000, 1'b0, 1'b0);

        // 3: saturation of the 2-bit counter; 8-bit counter keeps counting
        fault(16'h3000, OP_ST, 3'd1, 8'h22);
        for (int k = 0; k < 5; k++) fault(16'h3100, OP_LD, 3'd3, 8'h44);
        csr_read("t3_b_sat", A_STAT, 32'h0003_0001, 1'b1, 1'b1);
        csr_read("t3_a_cnt5", A_STAT, 32'h0005_0001, 1'b1, 1'b0);

        // 4: ack and new event together -> fresh record, count cleared
        ifa.irq_ack = 1'b1;
        fault(16'h0040, OP_LD, 3'd2, 8'h10);
        ifa.irq_ack = 1'b0;
        csr_read("t4_addr", A_ADDR, 32'h0000_0040, 1'b1, 1'b0);
        csr_read("t4_info", A_INFO, 32'h0000_0210, 1'b1, 1'b0);
        csr_read("t4_status", A_STAT, 32'h0000_0001, 1'b1, 1'b0);
        csr_read("t4_b_status", A_STAT, 32'h0000_0001, 1'b1, 1'b1);
        csr_write(A_ADDR, 32'h0000_FFFF);
        csr_read("t4_addr_ro", A_ADDR, 32'h0000_0040, 1'b1, 1'b0);
        csr_write(A_STAT, 32'h0000_0001);
        csr_read("t4_csr_release", A_STAT, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t4_addr_kept", A_ADDR, 32'h0000_0040, 1'b0, 1'b0);

        // 5: fault flag without valid is ignored; STATUS clear in IDLE does nothing
        ifa.mem_fault_in = 1'b1;
        ifa.addr         = 16'h7777;
        repeat (10) tick();
        ifa.mem_fault_in = 1'b0;
        csr_read("t5_no_capture", A_STAT, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t5_addr", A_ADDR, 32'h0000_0040, 1'b0, 1'b0);
        csr_write(A_STAT, 32'h0000_0001);
        csr_read("t5_idle_clear", A_STAT, 32'h0000_0000, 1'b0, 1'b0);

        // STATUS write with bit0 clear must not release
        fault(16'h0ABC, OP_ST, 3'd7, 8'hFF);
        csr_write(A_STAT, 32'hFFFF_FFFE);
        csr_read("bit0_zero_keep", A_STAT, 32'h0000_0001, 1'b1, 1'b0);
        csr_read("info_0abc", A_INFO, 32'h0000_0FFF, 1'b1, 1'b0);
        ifa.irq_ack = 1'b1;
        tick();
        ifa.irq_ack = 1'b0;

        // Read concurrent with an event returns the pre-edge value
        expect_push("rd_pre_edge", 32'h0000_0ABC, 1'b0, 1'b0);
        ifa.csr_addr    = A_ADDR;
        ifa.csr_read_en = 1'b1;
        set_access(16'h5555, OP_LD, 3'd4, 8'h01);
        tick();
        clr_access();
        ifa.csr_read_en = 1'b0;
        csr_read("rd_post_edge", A_ADDR, 32'h0000_5555, 1'b1, 1'b0);

        // 6: async reset drops IRQ without a clock edge
        ifa.csr_addr = A_STAT;
        reset        = 1'b0;
        #1;
        expect_push("t6_async_rst", 32'h0000_0000, 1'b0, 1'b0);
        chk_strobe = 1'b1;
        #1;
        chk_strobe = 1'b0;
        csr_read("t6_in_rst_addr", A_ADDR, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t6_in_rst_info", A_INFO, 32'h0000_0000, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        csr_read("t6_addr", A_ADDR, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t6_info", A_INFO, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t6_status", A_STAT, 32'h0000_0000, 1'b0, 1'b0);
        csr_read("t6_unmapped", BASE + 12'd3, 32'h0000_0000, 1'b0, 1'b0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
